// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core memory-side blocks.
package segre_pkg;

    localparam int ADDR_SIZE        = 32;
    localparam int WORD_SIZE        = 32;
    localparam int DCACHE_LANE_SIZE = 128;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_BUSY,
        MM_RESP
    } mm_fsm_state_e;

    localparam int MM_NUM_WORDS  = 4096;
    localparam int MM_LATENCY    = 5;
    localparam int MM_LANE_WORDS = DCACHE_LANE_SIZE / WORD_SIZE;

    // Alignment rule for the main-memory responder: lane reads must be
    // lane aligned, stores must be aligned to their own size.
    function automatic logic mm_misaligned(input logic             is_wr,
                                           input memop_data_type_e t,
                                           input logic [3:0]       low);
        logic bad;
        bad = 1'b0;
        if (!is_wr) begin
            bad = (low != 4'd0);
        end else begin
            case (t)
                HALF:    bad = low[0];
                WORD:    bad = (low[1:0] != 2'd0);
                default: bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/segre_mm_store_merge.sv
// Turns a right-aligned store into per-byte enables and word-positioned data.
module segre_mm_store_merge
    import segre_pkg::*;
(
    input  logic [1:0]           offset,
    input  memop_data_type_e     wr_type,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic [3:0]           byte_en,
    output logic [WORD_SIZE-1:0] word_data
);

    // Replicating the data lets the byte enable alone select the target bytes.
    always_comb begin
        byte_en   = 4'b0000;
        word_data = wr_data;
        case (wr_type)
            BYTE: begin
                byte_en   = 4'b0001 << offset;
                word_data = {4{wr_data[7:0]}};
            end
            HALF: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                word_data = {2{wr_data[15:0]}};
            end
            WORD: begin
                byte_en   = 4'b1111;
                word_data = wr_data;
            end
            default: begin
                byte_en   = 4'b0000;
                word_data = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/segre_main_memory.sv
// Main-memory responder: fixed-latency lane reads and sub-word stores.
// Optional alignment checking is enabled by defining SEGRE_MM_ALIGN_CHECK_EN.
//
// state   | meaning
// MM_IDLE | ready for a request; ready_o high
// MM_BUSY | counting down the access latency
// MM_RESP | one-cycle response (data_rdy_o, wr_done_o or error_o)
module segre_main_memory
    import segre_pkg::*;
#(
    parameter int MEM_WORDS = MM_NUM_WORDS,
    parameter int LATENCY   = MM_LATENCY
) (
    input  logic                        clk_i,
    input  logic                        rsn_i,
    input  logic                        rd_req_i,
    input  logic                        wr_req_i,
    input  logic [ADDR_SIZE-1:0]        addr_i,
    input  logic [WORD_SIZE-1:0]        wr_data_i,
    input  memop_data_type_e            wr_type_i,
    output logic                        ready_o,
    output logic                        data_rdy_o,
    output logic [DCACHE_LANE_SIZE-1:0] rd_data_o,
    output logic                        wr_done_o,
    output logic                        error_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;

    mm_fsm_state_e state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] data_q;
    memop_data_type_e     type_q;
    logic                 is_wr_q;
    logic                 err_q;

    logic                 accept;
    logic                 acc_err;
    logic [ADDR_SIZE-1:0] cur_addr;
    logic                 cur_wr;
    logic                 cur_err;
    logic                 enter_resp;
    logic [IW-1:0]        lane_base;
    logic [DCACHE_LANE_SIZE-1:0] lane_data;

    logic [3:0]           byte_en;
    logic [WORD_SIZE-1:0] word_data;
    logic                 mem_we;
    logic [IW-1:0]        wr_idx;

    logic [WORD_SIZE-1:0] mem [MEM_WORDS];

    // Write wins over a simultaneous read; the read stays pending upstream.
    assign accept = (state == MM_IDLE) && (rd_req_i || wr_req_i);

`ifdef SEGRE_MM_ALIGN_CHECK_EN
    assign acc_err = mm_misaligned(wr_req_i, wr_type_i, addr_i[3:0]);
`else
    assign acc_err = 1'b0;
`endif

    // State register and latency down-counter.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state <= MM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            MM_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = MM_RESP;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = MM_BUSY;
                        cnt_nx   = CW'(LATENCY - 1);
                    end
                end
            end
            MM_BUSY: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = MM_RESP;
                end
            end
            MM_RESP: begin
                state_nx = MM_IDLE;
            end
            default: begin
                state_nx = MM_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Capture the accepted request.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= BYTE;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr_i;
            data_q  <= wr_data_i;
            type_q  <= wr_type_i;
            is_wr_q <= wr_req_i;
            err_q   <= acc_err;
        end
    end

    // With LATENCY=1 the response follows acceptance directly, so the lane
    // fetch must look at the live request instead of the captured one.
    assign cur_addr   = (state == MM_IDLE) ? addr_i   : addr_q;
    assign cur_wr     = (state == MM_IDLE) ? wr_req_i : is_wr_q;
    assign cur_err    = (state == MM_IDLE) ? acc_err  : err_q;
    assign enter_resp = (state_nx == MM_RESP) && (state != MM_RESP);
    assign lane_base  = cur_addr[IW+1:2] & ~IW'(3);

    // Gather the four words of the addressed lane.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < MM_LANE_WORDS; k++) begin
            lane_data[WORD_SIZE*k +: WORD_SIZE] = mem[lane_base | IW'(k)];
        end
    end

    // Read data register; holds until the next successful read.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            rd_data_o <= '0;
        end else if (enter_resp && !cur_wr && !cur_err) begin
            rd_data_o <= lane_data;
        end
    end

    segre_mm_store_merge u_store_merge (
        .offset    (addr_q[1:0]),
        .wr_type   (type_q),
        .wr_data   (data_q),
        .byte_en   (byte_en),
        .word_data (word_data)
    );

    assign mem_we = (state == MM_RESP) && is_wr_q && !err_q;
    assign wr_idx = addr_q[IW+1:2];

    // Byte-enabled store commit at the edge that ends the response cycle.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[wr_idx][8*b +: 8] <= word_data[8*b +: 8];
                end
            end
        end
    end

    assign ready_o    = (state == MM_IDLE);
    assign data_rdy_o = (state == MM_RESP) && !is_wr_q && !err_q;
    assign wr_done_o  = (state == MM_RESP) &&  is_wr_q && !err_q;

`ifdef SEGRE_MM_ALIGN_CHECK_EN
    assign error_o = (state == MM_RESP) && err_q;
`else
    assign error_o = 1'b0;
`endif

    // Address bits above the array size wrap and are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur_addr[ADDR_SIZE-1:IW+2], cur_addr[1:0],
                                addr_q[ADDR_SIZE-1:IW+2]};

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed self-checking bench for segre_main_memory (LATENCY=5).
module tb_segre_main_memory;
    import segre_pkg::*;

    localparam int LAT = 5;

    logic                        clk_i = 1'b0;
    logic                        rsn_i = 1'b0;
    logic                        rd_req_i = 1'b0;
    logic                        wr_req_i = 1'b0;
    logic [ADDR_SIZE-1:0]        addr_i = '0;
    logic [WORD_SIZE-1:0]        wr_data_i = '0;
    memop_data_type_e            wr_type_i = WORD;
    logic                        ready_o;
    logic                        data_rdy_o;
    logic [DCACHE_LANE_SIZE-1:0] rd_data_o;
    logic                        wr_done_o;
    logic                        error_o;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] W0 = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
    localparam logic [127:0] ALL = {128{1'b1}};

    segre_main_memory #(.MEM_WORDS(4096), .LATENCY(LAT)) dut (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .rd_req_i   (rd_req_i),
        .wr_req_i   (wr_req_i),
        .addr_i     (addr_i),
        .wr_data_i  (wr_data_i),
        .wr_type_i  (wr_type_i),
        .ready_o    (ready_o),
        .data_rdy_o (data_rdy_o),
        .rd_data_o  (rd_data_o),
        .wr_done_o  (wr_done_o),
        .error_o    (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 read pulse, 1 write done, 2 alignment error
    task automatic wait_resp(input string tag, input int kind,
                             input logic [127:0] exp_lane, input logic [127:0] mask);
        int n;
        logic [2:0] pul;
        n = 0;
        pul = 3'b000;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk_i);
            pul = {error_o, wr_done_o, data_rdy_o};
            if (pul != 3'b000) n = i;
        end
        chk({tag, " latency"}, 128'(n), 128'(LAT));
        chk({tag, " pulse"}, 128'(pul), 128'(3'b001 << kind));
        if (kind == 0) chk({tag, " lane"}, rd_data_o & mask, exp_lane & mask);
        @(negedge clk_i);
        chk({tag, " ready after"}, 128'({ready_o, error_o, wr_done_o, data_rdy_o}), 128'(4'b1000));
        if (kind == 0) chk({tag, " lane hold"}, rd_data_o & mask, exp_lane & mask);
    endtask

    task automatic run_op(input string tag, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input memop_data_type_e t, input int kind,
                          input logic [127:0] exp_lane, input logic [127:0] mask);
        @(negedge clk_i);
        rd_req_i  = rd;
        wr_req_i  = wr;
        addr_i    = a;
        wr_data_i = d;
        wr_type_i = t;
        @(posedge clk_i);
        #1;
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        wait_resp(tag, kind, exp_lane, mask);
    endtask

    initial begin
        int wd_seen;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("reset outputs", 128'({ready_o, data_rdy_o, wr_done_o, error_o}), 128'(4'b1000));
        chk("reset rd_data", rd_data_o, 128'h0);
        rsn_i = 1'b1;
        @(negedge clk_i);
        chk("post-reset ready", 128'(ready_o), 128'(1'b1));

        // Single WORD store
        run_op("st 0x100", 0, 1, 32'h100, 32'hDEADBEEF, WORD, 1, '0, '0);

        // Four word stores then a lane read
        run_op("st 0x200", 0, 1, 32'h200, 32'h11111111, WORD, 1, '0, '0);
        run_op("st 0x204", 0, 1, 32'h204, 32'h22222222, WORD, 1, '0, '0);
        run_op("st 0x208", 0, 1, 32'h208, 32'h33333333, WORD, 1, '0, '0);
        run_op("st 0x20C", 0, 1, 32'h20C, 32'h44444444, WORD, 1, '0, '0);
        run_op("rd 0x200", 1, 0, 32'h200, 32'h0, WORD, 0,
               128'h44444444_33333333_22222222_11111111, ALL);

        // Sub-word merge
        run_op("st 0x300", 0, 1, 32'h300, 32'hAABBCCDD, WORD, 1, '0, '0);
        run_op("stb 0x302", 0, 1, 32'h302, 32'h00000077, BYTE, 1, '0, '0);
        run_op("sth 0x300", 0, 1, 32'h300, 32'h00001234, HALF, 1, '0, '0);
        run_op("rd 0x300", 1, 0, 32'h300, 32'h0, WORD, 0, 128'hAA771234, W0);

        // Address wrap: 0x4100 aliases 0x100
        run_op("rd wrap", 1, 0, 32'h4100, 32'h0, WORD, 0, 128'hDEADBEEF, W0);

        // Simultaneous read and write: write first, held read afterwards
        @(negedge clk_i);
        rd_req_i  = 1'b1;
        wr_req_i  = 1'b1;
        addr_i    = 32'h200;
        wr_data_i = 32'h55555555;
        wr_type_i = WORD;
        @(posedge clk_i);
        #1;
        wr_req_i = 1'b0;
        wait_resp("both wr", 1, '0, '0);
        @(posedge clk_i);
        #1;
        rd_req_i = 1'b0;
        wait_resp("both rd", 0, 128'h44444444_33333333_22222222_55555555, ALL);

        // Reset in the middle of a store
        run_op("st0 0x400", 0, 1, 32'h400, 32'h0, WORD, 1, '0, '0);
        @(negedge clk_i);
        wr_req_i  = 1'b1;
        addr_i    = 32'h400;
        wr_data_i = 32'h12345678;
        wr_type_i = WORD;
        @(posedge clk_i);
        #1;
        wr_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rsn_i = 1'b0;
        #2;
        chk("mid-reset outputs", 128'({ready_o, data_rdy_o, wr_done_o, error_o}), 128'(4'b1000));
        chk("mid-reset rd_data", rd_data_o, 128'h0);
        @(negedge clk_i);
        rsn_i = 1'b1;
        wd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (wr_done_o !== 1'b0 || ready_o !== 1'b1) wd_seen++;
        end
        chk("abandoned store quiet", 128'(wd_seen), 128'h0);
        run_op("rd 0x400", 1, 0, 32'h400, 32'h0, WORD, 0, 128'h0, W0);

        // Misaligned WORD store and invalid store size
        run_op("st0 0x500", 0, 1, 32'h500, 32'h0, WORD, 1, '0, '0);
`ifdef SEGRE_MM_ALIGN_CHECK_EN
        run_op("st 0x502", 0, 1, 32'h502, 32'hFEEDFACE, WORD, 2, '0, '0);
        run_op("rd 0x500", 1, 0, 32'h500, 32'h0, WORD, 0, 128'h0, W0);
`else
        run_op("st 0x502", 0, 1, 32'h502, 32'hFEEDFACE, WORD, 1, '0, '0);
        run_op("rd 0x500", 1, 0, 32'h500, 32'h0, WORD, 0, 128'hFEEDFACE, W0);
`endif
        run_op("st inv", 0, 1, 32'h500, 32'h99999999, memop_data_type_e'(2'b11), 1, '0, '0);
`ifdef SEGRE_MM_ALIGN_CHECK_EN
        run_op("rd after inv", 1, 0, 32'h500, 32'h0, WORD, 0, 128'h0, W0);
`else
        run_op("rd after inv", 1, 0, 32'h500, 32'h0, WORD, 0, 128'hFEEDFACE, W0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segre_main_memory.md
# segre_main_memory

Main-memory responder for the MMU's memory port: it accepts lane-fill reads and sub-word stores, holds each for a fixed latency, then returns a full 128-bit cache lane or a store acknowledge. It sits below the MMU and serves both data-cache and instruction-cache misses as well as store-buffer flushes. A small synchronous word array provides the backing storage.

## Interface
- MEM_WORDS, 4096, number of 32-bit words of storage; must be a power of two and at least 4.
- LATENCY, 5, cycles from request acceptance to the response pulse; must be at least 1.
- clk_i  in  1  core clock.
- rsn_i  in  1  reset; asynchronous, active-low.
- rd_req_i  in  1  lane read request.
- wr_req_i  in  1  store request.
- addr_i  in  ADDR_SIZE  byte address.
- wr_data_i  in  WORD_SIZE  store data, right-aligned.
- wr_type_i  in  memop_data_type_e  store size: BYTE, HALF or WORD.
- ready_o  out  1  responder idle; requests are accepted only while this is high.
- data_rdy_o  out  1  one-cycle pulse: rd_data_o is valid.
- rd_data_o  out  DCACHE_LANE_SIZE  lane read data; word k occupies bits [32k+31:32k].
- wr_done_o  out  1  one-cycle pulse: the store has been committed.
- error_o  out  1  one-cycle alignment error pulse; tied to 0 unless SEGRE_MM_ALIGN_CHECK_EN is defined.

## Operation
- FSM states are MM_IDLE, MM_BUSY and MM_RESP. ready_o is 1 only in MM_IDLE.
- Acceptance: a request is accepted at a rising edge where the state is MM_IDLE and rd_req_i or wr_req_i is 1. At that edge addr_i, wr_data_i, wr_type_i and the operation kind are captured.
- Simultaneous rd_req_i and wr_req_i: the write is accepted. The read is not accepted and must be held by the requester until ready_o returns.
- Transitions:
  - MM_IDLE to MM_BUSY on acceptance, with the counter loaded to LATENCY-1.
  - If LATENCY is 1, MM_IDLE goes directly to MM_RESP.
  - MM_BUSY decrements the counter and moves to MM_RESP when the counter reaches 1.
  - MM_RESP always returns to MM_IDLE after one cycle.
- Read: the lane base is addr with bits [3:0] cleared. In the MM_RESP cycle, rd_data_o holds the four words at that lane and data_rdy_o is 1. rd_data_o keeps this value until the next read completes.
- Write (little-endian byte enables):
  - BYTE writes wr_data_i[7:0] to byte addr[1:0].
  - HALF writes wr_data_i[15:0] to bytes {addr[1],0} and {addr[1],1}.
  - WORD writes all four bytes.
  - The array is updated at the edge that ends MM_RESP. wr_done_o is 1 during MM_RESP.
- Invalid wr_type_i (2'b11): no bytes are written, but wr_done_o still pulses.
- Addressing: the word index is addr[$clog2(MEM_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap around modulo the memory size.
- A read issued after a write completes returns the written data. A read and a write are never in flight at the same time.

## Timing
- Reset values: ready_o=1, data_rdy_o=0, wr_done_o=0, error_o=0, rd_data_o=0, state MM_IDLE, counter 0. Array contents are not reset.
- Latency: a request accepted at edge T produces its response pulse in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- ready_o rises in the cycle after the response pulse.
- Throughput: one request per LATENCY+1 cycles.
- Reset asserted mid-operation: the request is abandoned immediately. No write is committed and no pulse is generated.
- data_rdy_o and wr_done_o are never high in the same cycle.

## Configuration
- SEGRE_MM_ALIGN_CHECK_EN defined:
  - A read with addr[3:0]≠0, a HALF store with addr[0]=1, or a WORD store with addr[1:0]≠0 still runs the full latency.
  - Instead of the normal pulse, it pulses error_o in MM_RESP. No write occurs and rd_data_o is unchanged.
- SEGRE_MM_ALIGN_CHECK_EN not defined: error_o is constant 0 and misaligned low bits are silently ignored, as described in Operation.

## Structure
- Additions to segre_pkg:
  - mm_fsm_state_e {MM_IDLE, MM_BUSY, MM_RESP}.
  - MM_NUM_WORDS=4096 and MM_LATENCY=5, used as the defaults.
  - MM_LANE_WORDS = DCACHE_LANE_SIZE/WORD_SIZE.
- Sub-module segre_mm_store_merge: a combinational unit taking addr[1:0], wr_type_i and wr_data_i and producing a 4-bit byte enable and the lane-positioned write data.

## Test plan
- Reset with LATENCY=5 → ready_o=1 and all pulses 0. WORD store 0xDEADBEEF to 0x100 → wr_done_o pulses 5 cycles after acceptance and ready_o returns on the following cycle.
- WORD stores 0x11111111, 0x22222222, 0x33333333 and 0x44444444 to 0x200–0x20C, then a read of 0x200 → rd_data_o=0x44444444_33333333_22222222_11111111 with data_rdy_o high for exactly one cycle.
- WORD 0xAABBCCDD to 0x300, then BYTE 0x77 to 0x302, then HALF 0x1234 to 0x300 → the lane read at 0x300 returns word 0 = 0xAA771234.
- rd_req_i and wr_req_i asserted together while idle → only the write completes (wr_done_o). The read, held high, is accepted the cycle ready_o rises.
- rsn_i asserted 2 cycles into a WORD store to 0x400 (old value 0) → no wr_done_o, ready_o=1 after reset, and a read of 0x400 returns word 0 = 0.
- With SEGRE_MM_ALIGN_CHECK_EN, a WORD store to 0x502 → error_o pulses instead of wr_done_o and memory is unchanged. Without the macro the same store writes word 0x500.
